// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the shared-ALU arbiter slice.
//   - ALU opcode encodings. Opcodes above ALU_OP_XOR are illegal and produce 0.
//   - FSM state encoding for alu_arbiter.
//   - alu_op_illegal(): flags opcodes 101..111.
package alu_pkg;

    localparam logic [2:0] ALU_OP_ADD = 3'b000;
    localparam logic [2:0] ALU_OP_SUB = 3'b001;
    localparam logic [2:0] ALU_OP_AND = 3'b010;
    localparam logic [2:0] ALU_OP_OR  = 3'b011;
    localparam logic [2:0] ALU_OP_XOR = 3'b100;

    typedef enum logic [1:0] {
        ALU_ARB_IDLE = 2'd0,
        ALU_ARB_EXEC = 2'd1,
        ALU_ARB_RESP = 2'd2
    } alu_arb_state_e;

    function automatic logic alu_op_illegal(input logic [2:0] op);
        return op > ALU_OP_XOR;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response bundle between NREQ requesters and the
// shared ALU arbiter.
//   req_valid/req_ready  per-requester handshake (ready is one-hot or zero)
//   req_a/req_b          packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_op               packed opcodes, requester i at [i*3 +: 3]
//   rsp_*                registered response channel, valid/ready handshake
//   rsp_err              only present when ALU_ARB_ERR_EN is defined
// Modports: master = requester/consumer side, slave = arbiter side.
interface alu_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ*3-1:0]     req_op;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_result;
    logic                  rsp_zero;
`ifdef ALU_ARB_ERR_EN
    logic                  rsp_err;
`endif

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero
`ifdef ALU_ARB_ERR_EN
        , input rsp_err
`endif
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero
`ifdef ALU_ARB_ERR_EN
        , output rsp_err
`endif
    );

endinterface

// File: rtl/alu.sv
// alu: combinational ALU shared by the arbiter.
//   a, b    WIDTH-bit operands
//   op      opcode (alu_pkg ALU_OP_*); 101..111 give result 0
//   result  modulo-2^WIDTH result, carry/borrow dropped
//   zero    result == 0
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    always_comb begin
        result = '0;
        case (op)
            ALU_OP_ADD: result = a + b;
            ALU_OP_SUB: result = a - b;
            ALU_OP_AND: result = a & b;
            ALU_OP_OR:  result = a | b;
            ALU_OP_XOR: result = a ^ b;
            default:    result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/alu_rr_arb.sv
// alu_rr_arb: combinational round-robin picker.
//   req        request vector
//   last       index granted most recently; search starts at last+1 (wraps)
//   grant_oh   one-hot grant, zero when nothing requests
//   grant_idx  binary index of the grant
//   any        at least one request present
module alu_rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [NREQ-1:0] grant_oh,
    output logic [IDW-1:0]  grant_idx,
    output logic            any
);

    logic [IDW-1:0] cand;

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = '0;
        // Offsets 1..NREQ visit every index once, ending on last itself,
        // so the most recent winner has the lowest priority.
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(last) + k) % NREQ);
            if (!any && req[cand]) begin
                any            = 1'b1;
                grant_idx      = cand;
                grant_oh[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one alu between NREQ requesters.
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   alu_arbiter_if.slave (request handshakes in, tagged response out)
// Flow: IDLE grants one requester (round robin) and latches its operands,
// EXEC runs the alu and registers the response, RESP holds it until taken.
// One operation per 3 cycles at best; response valid 2 cycles after accept.
// Optional: define ALU_ARB_ERR_EN to add rsp_err (illegal opcode flag).
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input logic         clk,
    input logic         rst,
    alu_arbiter_if.slave bus
);

    localparam int IDW = $clog2(NREQ);

    alu_arb_state_e   state_q, state_d;
    logic [IDW-1:0]   last_q, last_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [2:0]       op_q, op_d;
    logic [IDW-1:0]   gidx_q, gidx_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic [IDW-1:0]   id_q, id_d;
`ifdef ALU_ARB_ERR_EN
    logic             err_q, err_d;
`endif

    logic [NREQ-1:0]  grant_oh;
    logic [IDW-1:0]   grant_idx;
    logic             grant_any;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    alu_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arb (
        .req       (bus.req_valid),
        .last      (last_q),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a      (opa_q),
        .b      (opb_q),
        .op     (op_q),
        .result (alu_result),
        .zero   (alu_zero)
    );

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        op_d     = op_q;
        gidx_d   = gidx_q;
        result_d = result_q;
        zero_d   = zero_q;
        id_d     = id_q;
`ifdef ALU_ARB_ERR_EN
        err_d    = err_q;
`endif
        case (state_q)
            ALU_ARB_IDLE: begin
                if (grant_any) begin
                    opa_d   = bus.req_a[grant_idx*WIDTH +: WIDTH];
                    opb_d   = bus.req_b[grant_idx*WIDTH +: WIDTH];
                    op_d    = bus.req_op[grant_idx*3 +: 3];
                    gidx_d  = grant_idx;
                    state_d = ALU_ARB_EXEC;
                end
            end
            ALU_ARB_EXEC: begin
                result_d = alu_result;
                zero_d   = alu_zero;
                id_d     = gidx_q;
`ifdef ALU_ARB_ERR_EN
                err_d    = alu_op_illegal(op_q);
`endif
                state_d  = ALU_ARB_RESP;
            end
            ALU_ARB_RESP: begin
                // Priority only advances once the response is consumed.
                if (bus.rsp_ready) begin
                    last_d  = gidx_q;
                    state_d = ALU_ARB_IDLE;
                end
            end
            default: state_d = ALU_ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ALU_ARB_IDLE;
            last_q   <= IDW'(NREQ - 1);
            opa_q    <= '0;
            opb_q    <= '0;
            op_q     <= '0;
            gidx_q   <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            id_q     <= '0;
`ifdef ALU_ARB_ERR_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            op_q     <= op_d;
            gidx_q   <= gidx_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            id_q     <= id_d;
`ifdef ALU_ARB_ERR_EN
            err_q    <= err_d;
`endif
        end
    end

    // The grant is combinational so the handshake completes in the IDLE cycle;
    // rst gates it so nothing is accepted while reset is held.
    assign bus.req_ready  = (state_q == ALU_ARB_IDLE && !rst) ? grant_oh : '0;
    assign bus.rsp_valid  = (state_q == ALU_ARB_RESP);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_zero   = zero_q;
`ifdef ALU_ARB_ERR_EN
    assign bus.rsp_err    = err_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scoreboard bench for alu_arbiter (WIDTH 8, NREQ 4).
// Stimulus pushes hand-computed responses into exp_q; the monitor pops and
// compares on every response handshake. An acceptor process watches grants.
// Define ALU_ARB_ERR_EN to also check rsp_err.
module tb_alu_arbiter;
    import alu_pkg::*;

    typedef struct {
        int         id;
        logic [7:0] res;
        logic       zero;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t exp_q[$];
    int   acc_count[4] = '{default: 0};
    int   acc_cyc = 0;
    int   last_acc = -1;
    logic gap_chk = 1'b0;

    alu_arbiter_if #(.WIDTH(8), .NREQ(4)) bus ();

    alu_arbiter #(.WIDTH(8), .NREQ(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out (cycle %0d)", name, cyc);
    endtask

    task automatic expect_rsp(input int id, input logic [7:0] res, input logic zero, input logic err);
        exp_t e;
        e.id = id; e.res = res; e.zero = zero; e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic start_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        bus.req_a[i*8 +: 8] = a;
        bus.req_b[i*8 +: 8] = b;
        bus.req_op[i*3 +: 3] = op;
        bus.req_valid[i] = 1'b1;
    endtask

    // Waits for requester i to be accepted (acc_count moves past start),
    // then optionally drops its valid in the following (EXEC) cycle.
    task automatic wait_accept(input int i, input int start, input bit drop);
        for (int t = 0; t < 40; t++) begin
            @(posedge clk); #1;
            if (acc_count[i] != start) begin
                if (drop) bus.req_valid[i] = 1'b0;
                return;
            end
        end
        fail($sformatf("accept_req%0d", i));
        bus.req_valid[i] = 1'b0;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                @(posedge clk); #1;
                return;
            end
        end
        fail("drain");
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    // Acceptor: observes grants, checks one-hot/valid-only and spacing.
    always @(negedge clk) begin
        if (rst) begin
            last_acc = -1;
        end else begin
            if (!gap_chk) last_acc = -1;
            if (bus.req_ready != 4'b0) begin
                int idx;
                idx = 0;
                for (int k = 0; k < 4; k++) if (bus.req_ready[k]) idx = k;
                chk("grant_onehot", $countones(bus.req_ready), 1);
                chk("grant_to_valid", bus.req_valid[idx], 1);
                if (last_acc >= 0) chk("accept_gap", cyc - last_acc, 3);
                last_acc = cyc;
                acc_cyc = cyc;
                acc_count[idx]++;
            end
        end
    end

    // Monitor: latency, hold-under-backpressure and scoreboard compare.
    logic       prev_valid = 1'b0;
    logic       hold_pending = 1'b0;
    logic [1:0] held_id = '0;
    logic [7:0] held_res = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                chk("hold_valid", bus.rsp_valid, 1);
                chk("hold_id", bus.rsp_id, held_id);
                chk("hold_result", bus.rsp_result, held_res);
            end
            if (bus.rsp_valid) chk("req_ready_in_resp", bus.req_ready, 0);
            if (bus.rsp_valid && !prev_valid) chk("latency", cyc, acc_cyc + 2);
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp actual id=%0d required none", bus.rsp_id);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("rsp id=%0d result=%02h zero=%0b (cycle %0d)",
                             bus.rsp_id, bus.rsp_result, bus.rsp_zero, cyc);
                    chk("rsp_id", bus.rsp_id, e.id);
                    chk("rsp_result", bus.rsp_result, e.res);
                    chk("rsp_zero", bus.rsp_zero, e.zero);
`ifdef ALU_ARB_ERR_EN
                    chk("rsp_err", bus.rsp_err, e.err);
`endif
                end
            end
            hold_pending = bus.rsp_valid && !bus.rsp_ready;
            held_id = bus.rsp_id;
            held_res = bus.rsp_result;
            prev_valid = bus.rsp_valid;
        end
    end

    initial begin
        int s, s1, s3, tot0;
        bit seen;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_op = '0;
        bus.rsp_ready = 1'b1;

        // Reset values, with a request pending that must not be granted.
        bus.req_valid[0] = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        chk("reset_rsp_id", bus.rsp_id, 0);
        chk("reset_rsp_result", bus.rsp_result, 0);
        chk("reset_rsp_zero", bus.rsp_zero, 0);
        chk("reset_req_ready", bus.req_ready, 0);
`ifdef ALU_ARB_ERR_EN
        chk("reset_rsp_err", bus.rsp_err, 0);
`endif
        bus.req_valid[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Req 0 ADD 0F+01.
        s = acc_count[0];
        expect_rsp(0, 8'h10, 1'b0, 1'b0);
        start_req(0, 8'h0F, 8'h01, ALU_OP_ADD);
        wait_accept(0, s, 1);
        wait_drain();

        // Req 2 SUB: 05-05 = 00, then 00-01 = FF (borrow dropped).
        s = acc_count[2];
        expect_rsp(2, 8'h00, 1'b1, 1'b0);
        start_req(2, 8'h05, 8'h05, ALU_OP_SUB);
        wait_accept(2, s, 1);
        wait_drain();
        s = acc_count[2];
        expect_rsp(2, 8'hFF, 1'b0, 1'b0);
        start_req(2, 8'h00, 8'h01, ALU_OP_SUB);
        wait_accept(2, s, 1);
        wait_drain();

        // Req 3 illegal opcode 111.
        s = acc_count[3];
        expect_rsp(3, 8'h00, 1'b1, 1'b1);
        start_req(3, 8'hAA, 8'h55, 3'b111);
        wait_accept(3, s, 1);
        wait_drain();

        // All four valid, last grant was 3: ids 0,1,2,3,0 every 3 cycles.
        gap_chk = 1'b1;
        expect_rsp(0, 8'h10, 1'b0, 1'b0);
        expect_rsp(1, 8'h30, 1'b0, 1'b0);
        expect_rsp(2, 8'h3F, 1'b0, 1'b0);
        expect_rsp(3, 8'h00, 1'b1, 1'b0);
        expect_rsp(0, 8'h10, 1'b0, 1'b0);
        tot0 = acc_count[0] + acc_count[1] + acc_count[2] + acc_count[3];
        start_req(0, 8'h0F, 8'h01, ALU_OP_ADD);
        start_req(1, 8'hF0, 8'h3C, ALU_OP_AND);
        start_req(2, 8'h0F, 8'h30, ALU_OP_OR);
        start_req(3, 8'hFF, 8'hFF, ALU_OP_XOR);
        seen = 0;
        for (int t = 0; t < 40 && !seen; t++) begin
            @(posedge clk); #1;
            if (acc_count[0] + acc_count[1] + acc_count[2] + acc_count[3] == tot0 + 5) seen = 1;
        end
        if (!seen) fail("five_accepts");
        bus.req_valid = '0;
        wait_drain();
        gap_chk = 1'b0;

        // Backpressure: hold response 5 cycles; req 2 arrives during RESP and waits.
        bus.rsp_ready = 1'b0;
        s = acc_count[1];
        expect_rsp(1, 8'hAA, 1'b0, 1'b0);
        expect_rsp(2, 8'h00, 1'b1, 1'b0);
        start_req(1, 8'hA5, 8'h0F, ALU_OP_XOR);
        wait_accept(1, s, 1);
        seen = 0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1;
        end
        if (!seen) fail("rsp_valid_backpressure");
        s = acc_count[2];
        start_req(2, 8'hFF, 8'h01, ALU_OP_ADD);
        repeat (5) begin
            @(negedge clk);
            chk("bp_req_ready", bus.req_ready, 0);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        wait_accept(2, s, 1);
        wait_drain();

        // Reset during EXEC of a req-3 operation: no response, priority restarts.
        s3 = acc_count[3];
        start_req(3, 8'h80, 8'h80, ALU_OP_ADD);
        wait_accept(3, s3, 0);
        rst = 1'b1;
        start_req(1, 8'h10, 8'h01, ALU_OP_SUB);
        repeat (3) begin
            @(negedge clk);
            chk("rst_rsp_valid", bus.rsp_valid, 0);
            chk("rst_req_ready", bus.req_ready, 0);
        end
        expect_rsp(1, 8'h0F, 1'b0, 1'b0);
        expect_rsp(3, 8'h00, 1'b1, 1'b0);
        s1 = acc_count[1];
        s3 = acc_count[3];
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_grant", bus.req_ready, 4'b0010);
        chk("post_rst_no_rsp", bus.rsp_valid, 0);
        wait_accept(1, s1, 1);
        wait_accept(3, s3, 1);
        wait_drain();

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
